// File: rtl/lcd_bus_scheduler.sv
// Two-requester arbiter and timing engine for an LCD1602 8-bit bus.
// Each accepted byte is driven through setup, enable pulse and a command-dependent settle wait.
module lcd_bus_scheduler #(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 20,
    parameter int GAP_CYC   = 2000,
    parameter int LONG_CYC  = 80000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic       a_last,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic       b_last,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] data,
    output logic       busy,
    output logic       owner
);

    localparam int MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_GL  = (GAP_CYC > LONG_CYC) ? GAP_CYC : LONG_CYC;
    localparam int MAX_ALL = (MAX_SE > MAX_GL) ? MAX_SE : MAX_GL;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, wait_load;
    logic             rs_q, owner_q, lock_q, last_grant_q;
    logic [7:0]       data_q;
    logic             grant_ok, grant_b, accept;
    logic             sel_rs, sel_last;
    logic [7:0]       sel_data;
    logic             long_cmd;

    // While locked only the owner can win, even if it has no byte to offer this cycle.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
        grant_ok = 1'b0;
        grant_b  = 1'b0;
        if (state == IDLE) begin
            if (lock_q) begin
                grant_b  = owner_q;
                grant_ok = owner_q ? b_valid : a_valid;
            end else if (a_valid && b_valid) begin
                grant_ok = 1'b1;
                grant_b  = ~last_grant_q;
            end else if (a_valid || b_valid) begin
                grant_ok = 1'b1;
                grant_b  = b_valid;
            end
        end
    end

    assign a_ready  = grant_ok && !grant_b;
    assign b_ready  = grant_ok && grant_b;
    assign accept   = grant_ok;
    assign sel_rs   = grant_b ? b_rs   : a_rs;
    assign sel_last = grant_b ? b_last : a_last;
    assign sel_data = grant_b ? b_data : a_data;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    assign long_cmd  = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);
    assign wait_load = long_cmd ? CNT_W'(LONG_CYC - 1) : CNT_W'(GAP_CYC - 1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            owner_q      <= 1'b0;
            lock_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                rs_q         <= sel_rs;
                data_q       <= sel_data;
                owner_q      <= grant_b;
                last_grant_q <= grant_b;
                lock_q       <= !sel_last;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_W'(EN_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = WAIT;
                    cnt_nxt   = wait_load;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en    = (state == PULSE);
        rw    = 1'b0;
        rs    = rs_q;
        data  = data_q;
        busy  = (state != IDLE) || lock_q;
        owner = owner_q;
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: directed scenarios plus random traffic,
// all compared cycle by cycle against an age-based model of each byte's lifetime.
module tb_lcd_bus_scheduler;

    localparam int S = 2;
    localparam int E = 3;
    localparam int G = 5;
    localparam int L = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_valid = 1'b0, a_rs = 1'b0, a_last = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       b_valid = 1'b0, b_rs = 1'b0, b_last = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       a_ready, b_ready, rs, rw, en, busy, owner;
    logic [7:0] data;

    lcd_bus_scheduler #(.SETUP_CYC(S), .EN_CYC(E), .GAP_CYC(G), .LONG_CYC(L)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rs(a_rs), .a_last(a_last), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rs(b_rs), .b_last(b_last), .b_data(b_data), .b_ready(b_ready),
        .rs(rs), .rw(rw), .en(en), .data(data), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: a byte lives S+E+wait cycles after its accept edge; age counts cycles since accept.
    bit         m_active, m_rs, m_lock, m_owner, m_last_grant;
    int         m_age, m_wait;
    logic [7:0] m_data;

    bit s_acc_a, s_acc_b, s_en, s_busy, s_ar;
    int s_cyc;

    task automatic model_reset();
        m_active = 0; m_age = 0; m_wait = 0; m_rs = 0; m_data = 8'h00;
        m_lock = 0; m_owner = 0; m_last_grant = 1;
    endtask

    task automatic do_reset();
        a_valid = 0; b_valid = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        model_reset();
    endtask

    task automatic cycle();
        bit gv, gb, e_ar, e_br, e_en, e_busy, lst;
        @(negedge clk);
        gv = 0; gb = 0;
        if (!m_active) begin
            if (m_lock) begin
                gb = m_owner; gv = m_owner ? b_valid : a_valid;
            end else if (a_valid && b_valid) begin
                gv = 1; gb = !m_last_grant;
            end else if (a_valid || b_valid) begin
                gv = 1; gb = b_valid;
            end
        end
        e_ar   = gv && !gb;
        e_br   = gv && gb;
        e_en   = m_active && (m_age >= S + 1) && (m_age <= S + E);
        e_busy = m_active || m_lock;
        vectors += 8;
        if (a_ready !== e_ar)  begin miscompares++; $display("FAIL a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, e_ar); end
        if (b_ready !== e_br)  begin miscompares++; $display("FAIL b_ready cyc=%0d got=%b exp=%b", cyc, b_ready, e_br); end
        if (en !== e_en)       begin miscompares++; $display("FAIL en cyc=%0d got=%b exp=%b", cyc, en, e_en); end
        if (rw !== 1'b0)       begin miscompares++; $display("FAIL rw cyc=%0d got=%b exp=0", cyc, rw); end
        if (rs !== m_rs)       begin miscompares++; $display("FAIL rs cyc=%0d got=%b exp=%b", cyc, rs, m_rs); end
        if (data !== m_data)   begin miscompares++; $display("FAIL data cyc=%0d got=%h exp=%h", cyc, data, m_data); end
        if (busy !== e_busy)   begin miscompares++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
        if (owner !== m_owner) begin miscompares++; $display("FAIL owner cyc=%0d got=%b exp=%b", cyc, owner, m_owner); end
        s_acc_a = a_valid && a_ready;
        s_acc_b = b_valid && b_ready;
        s_ar = a_ready; s_en = en; s_busy = busy; s_cyc = cyc;
        if (!reset) begin
            model_reset();
        end else if (gv) begin
            m_active = 1; m_age = 1; m_owner = gb; m_last_grant = gb;
            m_rs   = gb ? b_rs : a_rs;
            m_data = gb ? b_data : a_data;
            lst    = gb ? b_last : a_last;
            m_lock = !lst;
            m_wait = (!m_rs && m_data >= 8'd1 && m_data <= 8'd3) ? L : G;
        end else if (m_active) begin
            m_age++;
            if (m_age > S + E + m_wait) m_active = 0;
        end
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        vectors += 5;
        if (en !== 1'b0)      begin miscompares++; $display("FAIL reset_en got=%b exp=0", en); end
        if (rs !== 1'b0)      begin miscompares++; $display("FAIL reset_rs got=%b exp=0", rs); end
        if (data !== 8'h00)   begin miscompares++; $display("FAIL reset_data got=%h exp=00", data); end
        if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (owner !== 1'b0)   begin miscompares++; $display("FAIL reset_owner got=%b exp=0", owner); end
    endtask

    task automatic test_single_byte();
        int t_acc[$];
        int t_en[$];
        int ready_cnt = 0;
        do_reset();
        a_valid = 1; a_rs = 1; a_data = 8'h41; a_last = 1;
        for (int i = 0; i < 30 && t_acc.size() < 2; i++) begin
            cycle();
            if (s_ar) ready_cnt++;
            if (s_acc_a) t_acc.push_back(s_cyc);
            if (s_en) t_en.push_back(s_cyc);
        end
        a_valid = 0;
        vectors += 4;
        if (t_acc.size() != 2) begin
            miscompares++; $display("FAIL single_accepts got=%0d exp=2 (timeout)", t_acc.size());
        end else if (t_acc[1] - t_acc[0] != 11) begin
            miscompares++; $display("FAIL single_period got=%0d exp=11", t_acc[1] - t_acc[0]);
        end
        if (ready_cnt != 2) begin miscompares++; $display("FAIL single_ready_cycles got=%0d exp=2", ready_cnt); end
        if (t_en.size() != E) begin miscompares++; $display("FAIL single_en_len got=%0d exp=%0d", t_en.size(), E); end
        if (t_en.size() == 0 || t_acc.size() == 0) begin
            miscompares++; $display("FAIL single_en_start got=none exp=%0d", S + 1);
        end else if (t_en[0] - t_acc[0] != S + 1) begin
            miscompares++; $display("FAIL single_en_start got=%0d exp=%0d", t_en[0] - t_acc[0], S + 1);
        end
        repeat (12) cycle();
    endtask

    task automatic test_wait_len(input logic [7:0] d, input int exp_wait);
        bit seen_en = 0;
        bit got = 0;
        int n = 0;
        do_reset();
        a_valid = 1; a_rs = 0; a_data = d; a_last = 1;
        for (int i = 0; i < 5 && !got; i++) begin
            cycle();
            got = s_acc_a;
        end
        a_valid = 0;
        for (int i = 0; i < 40 && got; i++) begin
            cycle();
            if (s_en) seen_en = 1;
            else if (seen_en && s_busy) n++;
            else if (seen_en) break;
        end
        vectors++;
        if (!got || n != exp_wait) begin
            miscompares++; $display("FAIL wait_len data=%h got=%0d exp=%0d accepted=%b", d, n, exp_wait, got);
        end
    endtask

    task automatic test_round_robin();
        int k = 0;
        do_reset();
        a_valid = 1; a_rs = 1; a_data = 8'h61; a_last = 1;
        b_valid = 1; b_rs = 1; b_data = 8'h62; b_last = 1;
        for (int i = 0; i < 60 && k < 4; i++) begin
            cycle();
            if (s_acc_a || s_acc_b) begin
                vectors += 2;
                if (s_acc_b !== bit'(k % 2)) begin
                    miscompares++; $display("FAIL rr_order idx=%0d got_b=%b exp_b=%0d", k, s_acc_b, k % 2);
                end
                if (owner !== logic'(k % 2)) begin
                    miscompares++; $display("FAIL rr_owner idx=%0d got=%b exp=%0d", k, owner, k % 2);
                end
                k++;
            end
        end
        a_valid = 0; b_valid = 0;
        vectors++;
        if (k != 4) begin miscompares++; $display("FAIL rr_count got=%0d exp=4 (timeout)", k); end
        repeat (12) cycle();
    endtask

    task automatic test_lock();
        bit got = 0;
        bit b_early = 0;
        bit idle_seen = 0;
        do_reset();
        a_valid = 1; a_rs = 0; a_data = 8'hC0; a_last = 0;
        b_valid = 1; b_rs = 1; b_data = 8'h55; b_last = 1;
        for (int i = 0; i < 5 && !got; i++) begin
            cycle();
            got = s_acc_a;
        end
        a_valid = 0;
        repeat (20) begin
            cycle();
            if (s_acc_b) b_early = 1;
            if (!s_busy) idle_seen = 1;
        end
        a_valid = 1; a_rs = 1; a_data = 8'h00; a_last = 1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            if (s_acc_b) b_early = 1;
            if (!s_busy) idle_seen = 1;
            got = s_acc_a;
        end
        a_valid = 0;
        vectors += 3;
        if (!got)     begin miscompares++; $display("FAIL lock_second_a got=0 exp=1 (timeout)"); end
        if (b_early)  begin miscompares++; $display("FAIL lock_b_held got=granted exp=held"); end
        if (idle_seen) begin miscompares++; $display("FAIL lock_busy got=0 exp=1 throughout"); end
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            got = s_acc_b;
        end
        b_valid = 0;
        vectors++;
        if (!got) begin miscompares++; $display("FAIL lock_b_after got=0 exp=1 (timeout)"); end
        repeat (12) cycle();
    endtask

    task automatic test_reset_mid_pulse();
        bit got = 0;
        do_reset();
        a_valid = 1; a_rs = 1; a_data = 8'h5A; a_last = 1;
        for (int i = 0; i < 5 && !got; i++) begin
            cycle();
            got = s_acc_a;
        end
        a_valid = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            got = s_en;
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL midrst_pulse got=no_en exp=en (timeout)"); end
        reset = 0;
        cycle();
        reset = 1;
        vectors += 4;
        if (en !== 1'b0)     begin miscompares++; $display("FAIL midrst_en got=%b exp=0", en); end
        if (data !== 8'h00)  begin miscompares++; $display("FAIL midrst_data got=%h exp=00", data); end
        if (busy !== 1'b0)   begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (owner !== 1'b0)  begin miscompares++; $display("FAIL midrst_owner got=%b exp=0", owner); end
        a_valid = 1; a_rs = 1; a_data = 8'h31; a_last = 1;
        b_valid = 1; b_rs = 1; b_data = 8'h32; b_last = 1;
        cycle();
        vectors += 2;
        if (s_acc_a !== 1'b1) begin miscompares++; $display("FAIL midrst_tie_a got=%b exp=1", s_acc_a); end
        if (s_acc_b !== 1'b0) begin miscompares++; $display("FAIL midrst_tie_b got=%b exp=0", s_acc_b); end
        a_valid = 0; b_valid = 0;
        repeat (12) cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            if (!a_valid || s_acc_a) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_rs    = $urandom_range(0, 1);
                a_data  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                a_last  = ($urandom_range(0, 2) != 0);
            end
            if (!b_valid || s_acc_b) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_rs    = $urandom_range(0, 1);
                b_data  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                b_last  = ($urandom_range(0, 2) != 0);
            end
            cycle();
        end
        reset = 1; a_valid = 0; b_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_byte();
        test_wait_len(8'h01, L);
        test_wait_len(8'h03, L);
        test_wait_len(8'h80, G);
        test_wait_len(8'h00, G);
        test_wait_len(8'h04, G);
        test_round_robin();
        test_lock();
        test_reset_mid_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_bus_scheduler.md
LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4: cycles during which rs/data are stable with en low before the enable pulse.
REQ-002 SHALL have parameter EN_CYC, default 20: cycles that en is held high per byte.
REQ-003 SHALL have parameter GAP_CYC, default 2000: post-pulse wait for a normal byte (40 us at 50 MHz).
REQ-004 SHALL have parameter LONG_CYC, default 80000: post-pulse wait for clear/home commands (1.6 ms at 50 MHz).
REQ-005 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have ports a_valid, a_rs, a_last (inputs, 1 each) and a_data (input, 8): requester A byte offer, register-select, end-of-transaction marker, byte value.
REQ-008 SHALL have port a_ready, output, 1: requester A byte accepted this cycle when a_valid && a_ready.
REQ-009 SHALL have ports b_valid, b_rs, b_last, b_data, b_ready: identical semantics for requester B.
REQ-010 SHALL have ports rs, rw, en (outputs, 1 each) and data (output, 8): LCD1602 8-bit bus.
REQ-011 SHALL have port busy, output, 1: a byte is in flight or a transaction lock is held.
REQ-012 SHALL have port owner, output, 1: requester of the current or last accepted byte (0=A, 1=B).

Function
REQ-013 SHALL implement states IDLE, SETUP, PULSE, WAIT; transitions: IDLE->SETUP on accept; SETUP->PULSE after SETUP_CYC cycles; PULSE->WAIT after EN_CYC cycles; WAIT->IDLE after the wait count expires.
REQ-014 SHALL assert x_ready only in IDLE and only for the granted requester; at most one ready high per cycle; ready may depend combinationally on valids.
REQ-015 SHALL grant, when unlocked in IDLE: the sole valid requester; if both valid, the requester not granted last (round-robin); last_grant resets to B so A wins the first tie.
REQ-016 SHALL, on accepting a byte with last=0, lock the grant to that requester; while locked, only the owner may be granted, and the other requester is held off even if the owner deasserts valid.
REQ-017 SHALL release the lock when a byte with last=1 is accepted from the owner; round-robin pointer updates on every accept.
REQ-018 SHALL latch rs and data on accept and drive them unchanged through SETUP, PULSE and WAIT; data/rs hold their last values in IDLE.
REQ-019 SHALL drive en=1 exactly during PULSE (EN_CYC consecutive cycles), en=0 otherwise; rw SHALL be constant 0.
REQ-020 SHALL use LONG_CYC as the WAIT length when latched rs=0 and data is 0x01, 0x02 or 0x03 (data[7:2]==0 and data!=0); GAP_CYC otherwise, including rs=0 data=0x00.
REQ-021 SHALL produce a per-byte period of SETUP_CYC+EN_CYC+wait+1 cycles from accept to next possible accept (1 IDLE cycle).
REQ-022 SHALL size the single down-counter to $clog2(max of all parameters)+1 bits; no counter wraps.
REQ-023 SHALL assert busy when state != IDLE or lock held; owner updates on the accept cycle.
REQ-024 SHALL ignore valid changes and new offers while not in IDLE; offered bytes wait until accepted.

Reset
REQ-025 SHALL, when reset=0 at a clk edge, force state IDLE, en=0, rs=0, rw=0, data=0x00, busy=0, owner=0, lock cleared, last_grant=B, counter=0.
REQ-026 SHALL abort any in-flight byte on reset; en SHALL be 0 on the edge reset is sampled, even mid-PULSE, and the aborted byte is not retried.

Verification (SETUP_CYC=2, EN_CYC=3, GAP_CYC=5, LONG_CYC=12)
REQ-027 SHALL check: A offers rs=1 data=0x41 last=1 -> a_ready 1 cycle, en high 3 cycles after 2 setup cycles, next accept 11 cycles after first.
REQ-028 SHALL check: A offers rs=0 data=0x01 -> WAIT lasts 12 cycles; rs=0 data=0x80 -> WAIT 5 cycles.
REQ-029 SHALL check: A and B valid together with last=1 each -> order A,B,A,B; owner toggles 0,1,0,1.
REQ-030 SHALL check: A sends 0xC0(rs=0,last=0), drops valid 20 cycles, then 0x00(rs=1,last=1) while B valid throughout -> B not granted until after A's second byte; busy high throughout.
REQ-031 SHALL check: reset=0 on 2nd PULSE cycle -> en=0, data=0x00, busy=0 next edge; after release, A wins first tie.
